nano_mem_responder: RTL and testbench
=====================================

// Module: nano_mem_responder
// PURPOSE
//  Memory-side responder for the NanoCPU bus (address/dataR/dataW/ce/we).
//  Provides a 16-bit RAM plus a small memory-mapped I/O window.
//  The I/O window holds a TX stream FIFO with a valid/ready output and a free-running cycle counter.
//  It sits between the CPU and the testbench/LED logic as the single bus target.
// PARAMETERS
//  IO_BASE     8'hF0  addresses >= IO_BASE decode to I/O; below decode to RAM
//  FIFO_DEPTH  4      TX FIFO entries, power of two, 2..16
//  PROG_TOP    8'h40  write-protect limit (used only with NANO_MEM_WPROT_EN)
// PORTS
//  ck         in   1   clock, all state updates on rising edge
//  rst        in   1   reset, synchronous, active-high
//  address    in   8   word address from CPU
//  dataW      in   16  write data from CPU
//  ce         in   1   bus access enable
//  we         in   1   write strobe, qualified by ce
//  dataR      out  16  read data, combinational from address
//  out_data   out  16  TX FIFO head word
//  out_valid  out  1   FIFO not empty
//  out_ready  in   1   consumer accepts head when out_valid=1
//  err_wprot  out  1   sticky protected-write error
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, err_wprot=0.
//    On reset: FIFO empty, overflow flag=0, cycle counter=0. RAM contents are not reset.
//  - Read latency 0: dataR = f(address) in the same cycle. The CPU latches it on that edge.
//    ce=0 -> dataR=16'h0000.
//  - RAM write: ce&we&(address<IO_BASE) -> mem[address]<=dataW at the edge. Data is readable the next cycle.
//  - I/O map; offsets above F2 read 0 and ignore writes:
//     F0 TX: write pushes dataW. Read returns {13'b0, ovf, full, empty}.
//     F1 CYC: read returns counter. Write loads 0; counter reads 0 the next cycle, then increments.
//     F2 CTL: write of any value clears ovf. Read returns 0.
//  - Cycle counter: +1 every cycle while not in reset; 16'hFFFF wraps to 16'h0000.
//  - FIFO: pop when out_valid&&out_ready. out_data = head word, and 0 when empty.
//    Push while full with no pop in the same cycle -> word dropped, ovf<=1 (sticky).
//    Push+pop in the same cycle while full -> both succeed; count is unchanged and ovf stays unchanged.
//    Push while empty -> out_valid=1 from the next cycle. No bypass, so first-word latency is 1 cycle.
//    Pointers wrap modulo FIFO_DEPTH. The count is held in log2(FIFO_DEPTH)+1 bits.
//  - out_valid and out_data are stable while out_ready=0.
//  - rst asserted mid-transfer: FIFO is flushed at that edge; any head not yet popped is lost.
// CONFIGURATION
//  NANO_MEM_WPROT_EN defined:
//   - RAM writes with address<PROG_TOP are discarded (memory unchanged) and set err_wprot<=1.
//   - err_wprot clears only on rst or a CTL write.
//   - CTL write and a protected write in the same cycle cannot occur, since there is one address per cycle.
//  NANO_MEM_WPROT_EN undefined: all RAM addresses are writable; err_wprot is tied to 0.
// TESTING
//  1. Write 16'h1234 to 8'h20, then read 8'h20 -> dataR=16'h1234 the cycle after the write; ce=0 -> dataR=0.
//  2. Push A1,A2,A3 to F0 with out_ready=0 -> out_valid=1, out_data=A1, status=3'b000.
//     Then out_ready=1 -> A1,A2,A3 appear on consecutive cycles, then out_valid=0 and status=3'b001.
//  3. Fill 4 words, push a 5th -> dropped and status=3'b110.
//     Write F2 -> ovf=0. Full + push + pop in one cycle -> count stays 4 and ovf stays 0.
//  4. Cycle counter: read F1 twice 10 cycles apart -> difference is 10.
//     Write F1 -> next read 0. Preload via 65535 increments -> wraps to 0.
//  5. Push 2 words, assert rst for one cycle mid-drain -> out_valid=0, status=3'b001, counter=0.
//  6. With NANO_MEM_WPROT_EN: write 8'h10 -> memory unchanged, err_wprot=1; write 8'h50 succeeds.
//     Without the macro: the write to 8'h10 succeeds and err_wprot stays 0.

Source files
------------

// File: rtl/nano_mem_responder.sv
// NanoCPU bus target: word RAM below IO_BASE plus an I/O window (TX FIFO, cycle counter, control).
// Define NANO_MEM_WPROT_EN to write-protect RAM below PROG_TOP and report it on err_wprot.
module nano_mem_responder #(
    parameter logic [7:0] IO_BASE    = 8'hF0,
    parameter int         FIFO_DEPTH = 4
`ifdef NANO_MEM_WPROT_EN
    ,
    parameter logic [7:0] PROG_TOP   = 8'h40
`endif
) (
    input  logic        ck,
    input  logic        rst,
    input  logic [7:0]  address,
    input  logic [15:0] dataW,
    input  logic        ce,
    input  logic        we,
    output logic [15:0] dataR,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_wprot
);

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam int         RAM_WORDS = int'(IO_BASE);
    localparam logic [7:0] ADDR_TX   = IO_BASE;
    localparam logic [7:0] ADDR_CYC  = IO_BASE + 8'd1;
    localparam logic [7:0] ADDR_CTL  = IO_BASE + 8'd2;

    logic [15:0] ram [0:RAM_WORDS-1];
    logic [15:0] fifo_mem [0:FIFO_DEPTH-1];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   cyc_q, cyc_d;
    logic          err_q, err_d;

    logic is_ram, ram_we, push_req, push_ok, pop, ctl_wr, cyc_wr;
    logic fifo_full, fifo_empty;

    // Depth is a power of two, so the count's top bit alone marks full.
    assign fifo_full  = count_q[AW];
    assign fifo_empty = (count_q == '0);
    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr_q];
    assign err_wprot  = err_q;

    always_comb begin
        is_ram   = (address < IO_BASE);
        push_req = ce && we && (address == ADDR_TX);
        cyc_wr   = ce && we && (address == ADDR_CYC);
        ctl_wr   = ce && we && (address == ADDR_CTL);
        pop      = out_valid && out_ready;
        push_ok  = push_req && (!fifo_full || pop);
        err_d    = err_q;
`ifdef NANO_MEM_WPROT_EN
        ram_we   = ce && we && is_ram && (address >= PROG_TOP);
        if (ctl_wr) begin
            err_d = 1'b0;
        end else if (ce && we && is_ram && (address < PROG_TOP)) begin
            err_d = 1'b1;
        end
`else
        ram_we   = ce && we && is_ram;
        err_d    = 1'b0;
`endif

        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        ovf_d = ovf_q;
        if (ctl_wr) begin
            ovf_d = 1'b0;
        end else if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end

        cyc_d = cyc_wr ? 16'h0000 : cyc_q + 16'd1;
    end

    always_comb begin
        dataR = 16'h0000;
        if (ce) begin
            if (is_ram) begin
                dataR = ram[address];
            end else if (address == ADDR_TX) begin
                dataR = {13'b0, ovf_q, fifo_full, fifo_empty};
            end else if (address == ADDR_CYC) begin
                dataR = cyc_q;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            cyc_q    <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            cyc_q    <= cyc_d;
            err_q    <= err_d;
        end
    end

    // Storage arrays carry no reset; out_data masks stale FIFO slots while empty.
    always_ff @(posedge ck) begin
        if (ram_we) begin
            ram[address] <= dataW;
        end
        if (push_ok && !rst) begin
            fifo_mem[wr_ptr_q] <= dataW;
        end
    end

endmodule

// File: tb/tb_nano_mem_responder.sv
// Directed bench for nano_mem_responder: RAM, TX FIFO, cycle counter, reset flush and write protection.
// Build with NANO_MEM_WPROT_EN defined on both files to exercise the protected variant.
module tb_nano_mem_responder;

    logic        ck;
    logic        rst;
    logic [7:0]  address;
    logic [15:0] dataW;
    logic        ce;
    logic        we;
    logic [15:0] dataR;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        err_wprot;

    int errors = 0;
    int checks = 0;
    logic [15:0] cyc_first;
    logic [15:0] cyc_diff;

    nano_mem_responder dut (
        .ck        (ck),
        .rst       (rst),
        .address   (address),
        .dataW     (dataW),
        .ce        (ce),
        .we        (we),
        .dataR     (dataR),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_wprot (err_wprot)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [7:0] a, input logic [15:0] d);
        ce      = c;
        we      = w;
        address = a;
        dataW   = d;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        tick();
        tick();
        checkOutput("rst_valid", {15'b0, out_valid}, 16'h0000);
        checkOutput("rst_data", out_data, 16'h0000);
        checkOutput("rst_err", {15'b0, err_wprot}, 16'h0000);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'hF0, 16'h0000);
        checkOutput("rst_status", dataR, 16'h0001);
        applyStimulus(1'b1, 1'b0, 8'hF1, 16'h0000);
        checkOutput("rst_cyc", dataR, 16'h0000);

        applyStimulus(1'b1, 1'b1, 8'h20, 16'h1234);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h20, 16'h0000);
        checkOutput("ram_read", dataR, 16'h1234);
        applyStimulus(1'b0, 1'b0, 8'h20, 16'h0000);
        checkOutput("ce_low_read", dataR, 16'h0000);

        applyStimulus(1'b1, 1'b1, 8'hF3, 16'h5A5A);
        tick();
        applyStimulus(1'b1, 1'b0, 8'hF3, 16'h0000);
        checkOutput("f3_read", dataR, 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'hF2, 16'h0000);
        checkOutput("ctl_read", dataR, 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'hF0, 16'h0000);
        checkOutput("f3_no_push", dataR, 16'h0001);

        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00A1);
        checkOutput("push_no_bypass", {15'b0, out_valid}, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("first_valid", {15'b0, out_valid}, 16'h0001);
        checkOutput("first_data", out_data, 16'h00A1);
        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00A2);
        tick();
        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00A3);
        tick();
        applyStimulus(1'b1, 1'b0, 8'hF0, 16'h0000);
        checkOutput("three_status", dataR, 16'h0000);
        tick();
        tick();
        checkOutput("stall_data", out_data, 16'h00A1);
        out_ready = 1'b1;
        #1;
        checkOutput("drain_a1", out_data, 16'h00A1);
        tick();
        checkOutput("drain_a2", out_data, 16'h00A2);
        tick();
        checkOutput("drain_a3", out_data, 16'h00A3);
        tick();
        checkOutput("drain_empty_valid", {15'b0, out_valid}, 16'h0000);
        checkOutput("drain_empty_status", dataR, 16'h0001);
        out_ready = 1'b0;

        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00B1);
        tick();
        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00B2);
        tick();
        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00B3);
        tick();
        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00B4);
        tick();
        applyStimulus(1'b1, 1'b0, 8'hF0, 16'h0000);
        checkOutput("full_status", dataR, 16'h0002);
        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00B5);
        tick();
        applyStimulus(1'b1, 1'b0, 8'hF0, 16'h0000);
        checkOutput("ovf_status", dataR, 16'h0006);
        checkOutput("ovf_head", out_data, 16'h00B1);
        applyStimulus(1'b1, 1'b1, 8'hF2, 16'hFFFF);
        tick();
        applyStimulus(1'b1, 1'b0, 8'hF0, 16'h0000);
        checkOutput("ovf_cleared", dataR, 16'h0002);
        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00B6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'hF0, 16'h0000);
        checkOutput("full_pushpop_status", dataR, 16'h0002);
        checkOutput("full_pushpop_head", out_data, 16'h00B2);
        out_ready = 1'b1;
        tick();
        checkOutput("drain_b3", out_data, 16'h00B3);
        tick();
        checkOutput("drain_b4", out_data, 16'h00B4);
        tick();
        checkOutput("drain_b6", out_data, 16'h00B6);
        tick();
        checkOutput("drain_b_empty", {15'b0, out_valid}, 16'h0000);
        out_ready = 1'b0;

        applyStimulus(1'b1, 1'b0, 8'hF1, 16'h0000);
        cyc_first = dataR;
        repeat (10) tick();
        cyc_diff = dataR - cyc_first;
        checkOutput("cyc_diff10", cyc_diff, 16'd10);
        applyStimulus(1'b1, 1'b1, 8'hF1, 16'h1234);
        tick();
        applyStimulus(1'b1, 1'b0, 8'hF1, 16'h0000);
        checkOutput("cyc_load0", dataR, 16'h0000);
        tick();
        checkOutput("cyc_after_load", dataR, 16'h0001);
        repeat (65534) tick();
        checkOutput("cyc_max", dataR, 16'hFFFF);
        tick();
        checkOutput("cyc_wrap", dataR, 16'h0000);

        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00C1);
        tick();
        applyStimulus(1'b1, 1'b1, 8'hF0, 16'h00C2);
        tick();
        applyStimulus(1'b1, 1'b0, 8'hF0, 16'h0000);
        out_ready = 1'b1;
        #1;
        checkOutput("mid_c1", out_data, 16'h00C1);
        tick();
        checkOutput("mid_c2", out_data, 16'h00C2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'hF0, 16'h0000);
        checkOutput("flush_valid", {15'b0, out_valid}, 16'h0000);
        checkOutput("flush_status", dataR, 16'h0001);
        applyStimulus(1'b1, 1'b0, 8'hF1, 16'h0000);
        checkOutput("flush_cyc", dataR, 16'h0000);

`ifdef NANO_MEM_WPROT_EN
        applyStimulus(1'b1, 1'b1, 8'h10, 16'hBEEF);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h10, 16'h0000);
        checkOutput("wprot_blocked", {15'b0, (dataR == 16'hBEEF)}, 16'h0000);
        checkOutput("wprot_err_set", {15'b0, err_wprot}, 16'h0001);
        applyStimulus(1'b1, 1'b1, 8'h50, 16'hC0DE);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h50, 16'h0000);
        checkOutput("wprot_open_write", dataR, 16'hC0DE);
        checkOutput("wprot_err_sticky", {15'b0, err_wprot}, 16'h0001);
        applyStimulus(1'b1, 1'b1, 8'hF2, 16'h0000);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000);
        checkOutput("wprot_err_clear", {15'b0, err_wprot}, 16'h0000);
`else
        applyStimulus(1'b1, 1'b1, 8'h10, 16'hBEEF);
        tick();
        applyStimulus(1'b1, 1'b0, 8'h10, 16'h0000);
        checkOutput("low_write", dataR, 16'hBEEF);
        checkOutput("err_tied", {15'b0, err_wprot}, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
